pc_predict_unit: RTL and testbench
==================================

Name: pc_predict_unit

Overview:
- Fetch-stage PC generator for the pipelined RV32I core; replaces the purely combinational next-PC select with a registered PC.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, predicting taken branches and JAL at fetch.
- Resolves actual outcome in execute; drives Hazard_PCsrc (flush F/D) only on misprediction.

Parameters:
DATA_WIDTH, 32, PC/data width
BTB_ENTRIES, 16, BTB/counter entries; power of two >= 2; IDX = log2(BTB_ENTRIES)
RESET_PC, 0, PCF value after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
StallF  in  1  hold PCF (load-use hazard)
PCsrcE  in  3  execute branch type: `NEXT_PC, `EQ_TRUE, `EQ_FALSE, `UC_JUMP, `JALR (definitions.sv)
eq  in  1  execute comparator result
PCE  in  DATA_WIDTH  PC of execute instruction
PCTargetE  in  DATA_WIDTH  PCE + ImmExt
ALUResult  in  DATA_WIDTH  JALR target (rs1 + imm)
PredTakenE  in  1  prediction made for the execute instruction (pipelined from PredTakenF)
PCF  out  DATA_WIDTH  current fetch PC (registered)
PCPlus4F  out  DATA_WIDTH  PCF + 4
PredTakenF  out  1  fetch prediction for PCF (combinational)
Hazard_PCsrc  out  1  mispredict: flush F/D, combinational in resolve cycle

Behaviour:
- Index = PC[IDX+1:2]; tag = PC[DATA_WIDTH-1:IDX+2]. Entry = {valid, tag, target[DATA_WIDTH-1:0], ctr[1:0]}.
- Lookup (combinational on PCF): hit = valid && tag match; PredTakenF = hit && ctr[1]; predicted next = stored target if PredTakenF, else PCPlus4F.
- Resolve (combinational on E inputs): ActualTaken = (`EQ_TRUE && eq) || (`EQ_FALSE && !eq) || `UC_JUMP || `JALR. Correct target: `JALR -> {ALUResult[DATA_WIDTH-1:1],1'b0}; other taken -> PCTargetE; not taken -> PCE + 4.
- Hazard_PCsrc = 1 when PCsrcE is `JALR (always, never predicted), or when PCsrcE is `EQ_TRUE/`EQ_FALSE/`UC_JUMP and ActualTaken != PredTakenE. `NEXT_PC and unrecognised codes: 0, no BTB update.
- PC register, priority order at posedge: rst -> RESET_PC; Hazard_PCsrc -> correct target; StallF -> hold; else predicted next. Redirect overrides StallF.
- BTB update at posedge, only for `EQ_TRUE/`EQ_FALSE/`UC_JUMP, independent of StallF:
  - Hit at PCE index/tag: ctr saturating +1 if taken, -1 if not taken (00 and 11 saturate); target <= PCTargetE when taken.
  - Miss and taken: allocate valid=1, tag, target=PCTargetE, ctr=10 (overwrites any entry).
  - Miss and not taken: no change.
  - `JALR never allocates or updates.
- Execute never stalls; bubbles arrive as `NEXT_PC, so each branch updates exactly once.
- Same-cycle lookup and update on one index: lookup sees pre-update contents; new contents visible next cycle.
- Reset: PCF = RESET_PC; all valid = 0, ctr = 01, tags/targets cleared. Outputs then PCPlus4F = RESET_PC+4, PredTakenF = 0, Hazard_PCsrc = 0 (assuming execute holds `NEXT_PC). Reset mid-run discards any redirect in that cycle.
- Arithmetic modulo 2^DATA_WIDTH: PC wraps 0xFFFFFFFC -> 0x00000000, no flag.

Test Plan:
- Reset with RESET_PC=0, no stall, all E=`NEXT_PC -> PCF 0,4,8,12 on successive cycles; PredTakenF=0; Hazard_PCsrc=0 throughout.
- First `EQ_TRUE at PCE=0x10, eq=1, PCTargetE=0x40, PredTakenE=0 -> Hazard_PCsrc=1 that cycle, PCF=0x40 next; entry 4 allocated ctr=10. Later PCF=0x10 -> PredTakenF=1, next PCF=0x40.
- Same branch resolved with PredTakenE=1, eq=0 -> Hazard_PCsrc=1, PCF=0x14 next, ctr 10->01; subsequent fetch of 0x10 gives PredTakenF=0.
- `JALR with ALUResult=0x101 -> Hazard_PCsrc=1, PCF=0x100 next, BTB unchanged.
- StallF=1 with no redirect -> PCF held 2 cycles; StallF=1 together with mispredict -> PCF takes redirect target.
- Aliasing: taken branches at 0x10 and 0x50 (same index, BTB_ENTRIES=16) -> second allocation evicts first; fetch of 0x10 then misses (PredTakenF=0).

Source files
------------

// File: rtl/pc_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_predict_unit
// Brief    : Registered fetch PC with a direct-mapped BTB and 2-bit counters.
// Revision : 1.0 - initial release
// ============================================================================
module pc_predict_unit #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    BTB_ENTRIES = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic [2:0]            PCsrcE,
  input  logic                  eq,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic                  PredTakenE,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  PredTakenF,
  output logic                  Hazard_PCsrc
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX - 2;

  // Branch-type encodings shared with the core's definitions.sv
  localparam logic [2:0] c_next_pc  = 3'd0;
  localparam logic [2:0] c_eq_true  = 3'd1;
  localparam logic [2:0] c_eq_false = 3'd2;
  localparam logic [2:0] c_uc_jump  = 3'd3;
  localparam logic [2:0] c_jalr     = 3'd4;

  localparam logic [DATA_WIDTH-1:0] c_four = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;

  logic                  valid_q  [BTB_ENTRIES];
  logic                  valid_d  [BTB_ENTRIES];
  logic [TAG_W-1:0]      tag_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]      tag_d    [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0] target_d [BTB_ENTRIES];
  logic [1:0]            ctr_q    [BTB_ENTRIES];
  logic [1:0]            ctr_d    [BTB_ENTRIES];

  logic [IDX-1:0]        w_f_idx, w_e_idx;
  logic [TAG_W-1:0]      w_f_tag, w_e_tag;
  logic                  w_f_hit, w_e_hit;
  logic [DATA_WIDTH-1:0] w_pred_next;
  logic                  w_is_branch, w_is_jalr, w_actual_taken;
  logic [DATA_WIDTH-1:0] w_correct_target;
  logic                  unused_alu_lsb;

  assign unused_alu_lsb = ALUResult[0];

  // Fetch-side lookup
  assign w_f_idx     = pc_q[IDX+1:2];
  assign w_f_tag     = pc_q[DATA_WIDTH-1:IDX+2];
  assign w_f_hit     = valid_q[w_f_idx] && (tag_q[w_f_idx] == w_f_tag);
  assign PCF         = pc_q;
  assign PCPlus4F    = pc_q + c_four;
  assign PredTakenF  = w_f_hit && ctr_q[w_f_idx][1];
  assign w_pred_next = PredTakenF ? target_q[w_f_idx] : PCPlus4F;

  // Execute-side resolution
  assign w_e_idx     = PCE[IDX+1:2];
  assign w_e_tag     = PCE[DATA_WIDTH-1:IDX+2];
  assign w_e_hit     = valid_q[w_e_idx] && (tag_q[w_e_idx] == w_e_tag);
  assign w_is_jalr   = (PCsrcE == c_jalr);
  assign w_is_branch = (PCsrcE == c_eq_true) || (PCsrcE == c_eq_false) ||
                       (PCsrcE == c_uc_jump);

  assign w_actual_taken = ((PCsrcE == c_eq_true)  &&  eq) ||
                          ((PCsrcE == c_eq_false) && !eq) ||
                          (PCsrcE == c_uc_jump) || w_is_jalr;

  always_comb begin
    w_correct_target = PCE + c_four;
    if (w_is_jalr) begin
      w_correct_target = {ALUResult[DATA_WIDTH-1:1], 1'b0};
    end else if (w_actual_taken) begin
      w_correct_target = PCTargetE;
    end
  end

  // JALR is never predicted, so it always redirects
  assign Hazard_PCsrc = w_is_jalr || (w_is_branch && (w_actual_taken != PredTakenE));

  always_comb begin
    pc_d = w_pred_next;
    if (Hazard_PCsrc) begin
      pc_d = w_correct_target;
    end else if (StallF) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (w_is_branch) begin
      if (w_e_hit) begin
        if (w_actual_taken) begin
          target_d[w_e_idx] = PCTargetE;
          if (ctr_q[w_e_idx] != 2'b11) begin
            ctr_d[w_e_idx] = ctr_q[w_e_idx] + 2'b01;
          end
        end else if (ctr_q[w_e_idx] != 2'b00) begin
          ctr_d[w_e_idx] = ctr_q[w_e_idx] - 2'b01;
        end
      end else if (w_actual_taken) begin
        // Allocation evicts whatever alias occupied this index
        valid_d[w_e_idx]  = 1'b1;
        tag_d[w_e_idx]    = w_e_tag;
        target_d[w_e_idx] = PCTargetE;
        ctr_d[w_e_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_predict_unit
// Brief    : Directed self-checking bench for pc_predict_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_predict_unit;

  localparam logic [2:0] c_next_pc  = 3'd0;
  localparam logic [2:0] c_eq_true  = 3'd1;
  localparam logic [2:0] c_eq_false = 3'd2;
  localparam logic [2:0] c_uc_jump  = 3'd3;
  localparam logic [2:0] c_jalr     = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF;
  logic [2:0]  PCsrcE;
  logic        eq;
  logic [31:0] PCE;
  logic [31:0] PCTargetE;
  logic [31:0] ALUResult;
  logic        PredTakenE;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        PredTakenF;
  logic        Hazard_PCsrc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_predict_unit #(
    .DATA_WIDTH (32),
    .BTB_ENTRIES(16),
    .RESET_PC   (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .StallF      (StallF),
    .PCsrcE      (PCsrcE),
    .eq          (eq),
    .PCE         (PCE),
    .PCTargetE   (PCTargetE),
    .ALUResult   (ALUResult),
    .PredTakenE  (PredTakenE),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .PredTakenF  (PredTakenF),
    .Hazard_PCsrc(Hazard_PCsrc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    StallF     = 1'b0;
    PCsrcE     = c_next_pc;
    eq         = 1'b0;
    PCE        = 32'h0;
    PCTargetE  = 32'h0;
    ALUResult  = 32'h0;
    PredTakenE = 1'b0;
  endtask

  // Redirect fetch with a JALR from an unrelated PC (JALR never touches the BTB)
  task automatic jump_to(input logic [31:0] addr);
    set_idle();
    PCsrcE    = c_jalr;
    PCE       = 32'h200;
    ALUResult = addr;
    tick();
    set_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf: got %h expected %h", PCF, 32'h0); end
    checks++; if (PCPlus4F !== 32'h4) begin errors++; $display("FAIL reset_pcplus4: got %h expected %h", PCPlus4F, 32'h4); end
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b expected 0", PredTakenF); end
    checks++; if (Hazard_PCsrc !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b expected 0", Hazard_PCsrc); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      #1;
      checks++; if (PCF !== 32'(4 * k)) begin errors++; $display("FAIL seq_pcf%0d: got %h expected %h", k, PCF, 32'(4 * k)); end
      checks++; if (PredTakenF !== 1'b0 || Hazard_PCsrc !== 1'b0) begin errors++; $display("FAIL seq_flags%0d: got pred=%b haz=%b expected 0/0", k, PredTakenF, Hazard_PCsrc); end
    end
  endtask

  task automatic test_alloc();
    PCsrcE = c_eq_true; PCE = 32'h10; eq = 1'b1; PCTargetE = 32'h40; PredTakenE = 1'b0;
    #1;
    checks++; if (Hazard_PCsrc !== 1'b1) begin errors++; $display("FAIL alloc_hazard: got %b expected 1", Hazard_PCsrc); end
    tick(); set_idle(); #1;
    checks++; if (PCF !== 32'h40) begin errors++; $display("FAIL alloc_redirect: got %h expected %h", PCF, 32'h40); end
    jump_to(32'h10); #1;
    checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL alloc_pred: got %b expected 1", PredTakenF); end
    tick(); #1;
    checks++; if (PCF !== 32'h40) begin errors++; $display("FAIL alloc_follow: got %h expected %h", PCF, 32'h40); end
  endtask

  task automatic test_mispredict();
    PCsrcE = c_eq_true; PCE = 32'h10; eq = 1'b0; PCTargetE = 32'h40; PredTakenE = 1'b1;
    #1;
    checks++; if (Hazard_PCsrc !== 1'b1) begin errors++; $display("FAIL misp_hazard: got %b expected 1", Hazard_PCsrc); end
    tick(); set_idle(); #1;
    checks++; if (PCF !== 32'h14) begin errors++; $display("FAIL misp_redirect: got %h expected %h", PCF, 32'h14); end
    jump_to(32'h10); #1;
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL misp_pred: got %b expected 0", PredTakenF); end
    PCsrcE = c_eq_false; PCE = 32'h20; eq = 1'b1; PredTakenE = 1'b0;
    #1;
    checks++; if (Hazard_PCsrc !== 1'b0) begin errors++; $display("FAIL correct_nt_hazard: got %b expected 0", Hazard_PCsrc); end
    tick(); set_idle(); #1;
    checks++; if (PCF !== 32'h14) begin errors++; $display("FAIL correct_nt_pcf: got %h expected %h", PCF, 32'h14); end
  endtask

  task automatic test_jalr();
    PCsrcE = c_jalr; PCE = 32'h10; ALUResult = 32'h101;
    #1;
    checks++; if (Hazard_PCsrc !== 1'b1) begin errors++; $display("FAIL jalr_hazard: got %b expected 1", Hazard_PCsrc); end
    tick(); set_idle(); #1;
    checks++; if (PCF !== 32'h100) begin errors++; $display("FAIL jalr_target: got %h expected %h", PCF, 32'h100); end
    jump_to(32'h10); #1;
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL jalr_no_update: got %b expected 0", PredTakenF); end
  endtask

  task automatic test_stall();
    StallF = 1'b1;
    tick(); #1;
    checks++; if (PCF !== 32'h10) begin errors++; $display("FAIL stall_hold1: got %h expected %h", PCF, 32'h10); end
    tick(); #1;
    checks++; if (PCF !== 32'h10) begin errors++; $display("FAIL stall_hold2: got %h expected %h", PCF, 32'h10); end
    PCsrcE = c_eq_true; PCE = 32'h30; eq = 1'b1; PCTargetE = 32'h80; PredTakenE = 1'b0;
    #1;
    checks++; if (Hazard_PCsrc !== 1'b1) begin errors++; $display("FAIL stall_misp_hazard: got %b expected 1", Hazard_PCsrc); end
    tick(); set_idle(); #1;
    checks++; if (PCF !== 32'h80) begin errors++; $display("FAIL stall_redirect: got %h expected %h", PCF, 32'h80); end
  endtask

  task automatic test_alias();
    PCsrcE = c_eq_true; PCE = 32'h10; eq = 1'b1; PCTargetE = 32'h40; PredTakenE = 1'b0;
    tick(); set_idle();
    jump_to(32'h10); #1;
    checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL alias_retrain: got %b expected 1", PredTakenF); end
    PCsrcE = c_uc_jump; PCE = 32'h50; PCTargetE = 32'h90; PredTakenE = 1'b0;
    #1;
    checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL alias_preupdate: got %b expected 1", PredTakenF); end
    checks++; if (Hazard_PCsrc !== 1'b1) begin errors++; $display("FAIL alias_hazard: got %b expected 1", Hazard_PCsrc); end
    tick(); set_idle(); #1;
    checks++; if (PCF !== 32'h90) begin errors++; $display("FAIL alias_redirect: got %h expected %h", PCF, 32'h90); end
    jump_to(32'h10); #1;
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL alias_evicted: got %b expected 0", PredTakenF); end
    jump_to(32'h50); #1;
    checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL alias_new_pred: got %b expected 1", PredTakenF); end
    tick(); #1;
    checks++; if (PCF !== 32'h90) begin errors++; $display("FAIL alias_new_follow: got %h expected %h", PCF, 32'h90); end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 2; k++) begin
      PCsrcE = c_uc_jump; PCE = 32'h50; PCTargetE = 32'h90; PredTakenE = 1'b1;
      #1;
      checks++; if (Hazard_PCsrc !== 1'b0) begin errors++; $display("FAIL sat_hazard%0d: got %b expected 0", k, Hazard_PCsrc); end
      tick();
    end
    PCsrcE = c_eq_true; PCE = 32'h50; eq = 1'b0; PCTargetE = 32'h90; PredTakenE = 1'b1;
    tick(); set_idle();
    jump_to(32'h50); #1;
    checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL sat_pred: got %b expected 1", PredTakenF); end
  endtask

  task automatic test_wrap();
    jump_to(32'hFFFF_FFFC); #1;
    checks++; if (PCPlus4F !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h expected %h", PCPlus4F, 32'h0); end
    tick(); #1;
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL wrap_pcf: got %h expected %h", PCF, 32'h0); end
  endtask

  task automatic test_reset_mid();
    jump_to(32'h300);
    PCsrcE = c_eq_true; PCE = 32'h50; eq = 1'b0; PCTargetE = 32'h90; PredTakenE = 1'b1;
    rst = 1'b1;
    tick(); rst = 1'b0; set_idle(); #1;
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL rstmid_pcf: got %h expected %h", PCF, 32'h0); end
    jump_to(32'h50); #1;
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL rstmid_btb_clear: got %b expected 0", PredTakenF); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alloc();
    test_mispredict();
    test_jalr();
    test_stall();
    test_alias();
    test_saturate();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
